// File: rtl/pending_encoder_32x5_pkg.sv
// Shared definitions for the pending-bitmap encoder: widths, FSM states
// and the lowest-set-bit clear helper.
package pending_encoder_32x5_pkg;

    localparam int WIDTH = 32;
    localparam int IDXW  = 5;
    localparam int CNTW  = 6;

    typedef enum logic {
        PE_IDLE = 1'b0,
        PE_EMIT = 1'b1
    } pe_state_t;

    // Drop the lowest set bit of a bitmap (the one currently being served).
    function automatic logic [WIDTH-1:0] clear_lowest(input logic [WIDTH-1:0] v);
        clear_lowest = v & (v - {{(WIDTH-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/priority_enc_32x5.sv
// Combinational lowest-index encoder: isolates the lowest set bit and
// folds the resulting one-hot vector into a binary index with OR trees.
module priority_enc_32x5
    import pending_encoder_32x5_pkg::*;
(
    input  logic [WIDTH-1:0] pend,
    output logic [IDXW-1:0]  idx,
    output logic             nz
);

    logic [WIDTH-1:0] iso;

    // Lowest-bit isolate, then OR each one-hot position into the index bits it sets.
    always_comb begin
        iso = pend & (~pend + {{(WIDTH-1){1'b0}}, 1'b1});
        idx = {IDXW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            idx = idx | ({IDXW{iso[i]}} & IDXW'(i));
        end
        nz = |pend;
    end

endmodule

// File: rtl/pending_encoder_32x5.sv
// Sequential 32-to-5 encoder: captures a request bitmap and serially
// emits the index of each set bit, lowest first, under VALID/ACK.
module pending_encoder_32x5
    import pending_encoder_32x5_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] REQ,
    input  logic             CLR,
    input  logic             ACK,
    output logic             VALID,
    output logic [IDXW-1:0]  IDX,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] PEND,
    output logic [CNTW-1:0]  CNT
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    pe_state_t        state_r, state_s;
    logic [WIDTH-1:0] pend_r,  pend_s;
    logic [CNTW-1:0]  cnt_r,   cnt_s;
    logic             done_r,  done_s;
    logic [IDXW-1:0]  enc_idx;
    logic             enc_nz;
    logic [WIDTH-1:0] pend_cleared;

    priority_enc_32x5 u_enc (
        .pend (pend_r),
        .idx  (enc_idx),
        .nz   (enc_nz)
    );

    assign pend_cleared = clear_lowest(pend_r);

    // State, pending bitmap, served count and done pulse registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= PE_IDLE;
            pend_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; abort beats ACK and LOAD, LOAD only acts in IDLE.
    always_comb begin
        state_s = state_r;
        pend_s  = pend_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        if (CLR) begin
            pend_s  = {WIDTH{1'b0}};
            state_s = PE_IDLE;
        end else begin
            case (state_r)
                PE_IDLE: begin
                    if (LOAD) begin
                        pend_s = REQ;
                        cnt_s  = {CNTW{1'b0}};
                        if (REQ != {WIDTH{1'b0}}) begin
                            state_s = PE_EMIT;
                        end else begin
                            done_s = 1'b1;
                        end
                    end else begin
                        state_s = PE_IDLE;
                    end
                end
                PE_EMIT: begin
                    if (ACK) begin
                        pend_s = pend_cleared;
                        cnt_s  = cnt_r + CNT_ONE;
                        if (pend_cleared == {WIDTH{1'b0}}) begin
                            state_s = PE_IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = PE_EMIT;
                        end
                    end else begin
                        state_s = PE_EMIT;
                    end
                end
                default: begin
                    state_s = PE_IDLE;
                    pend_s  = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Outputs are direct decodes of registered state; IDX is forced to 0 unless valid.
    always_comb begin
        VALID = (state_r == PE_EMIT);
        BUSY  = (state_r == PE_EMIT);
        if ((state_r == PE_EMIT) && enc_nz) begin
            IDX = enc_idx;
        end else begin
            IDX = {IDXW{1'b0}};
        end
        DONE = done_r;
        PEND = pend_r;
        CNT  = cnt_r;
    end

endmodule

// File: tb/tb_pending_encoder_32x5.sv
// Self-checking bench for pending_encoder_32x5: behavioural model plus
// per-cycle compare, directed scenarios and a randomized phase.
module tb_pending_encoder_32x5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        LOAD = 1'b0;
    logic [31:0] REQ = 32'd0;
    logic        CLR = 1'b0;
    logic        ACK = 1'b0;
    logic        VALID;
    logic [4:0]  IDX;
    logic        BUSY;
    logic        DONE;
    logic [31:0] PEND;
    logic [5:0]  CNT;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pend = 32'd0;
    int          m_cnt  = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;

    pending_encoder_32x5 dut (
        .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .REQ(REQ), .CLR(CLR), .ACK(ACK),
        .VALID(VALID), .IDX(IDX), .BUSY(BUSY), .DONE(DONE), .PEND(PEND), .CNT(CNT)
    );

    always #5 CLK = ~CLK;

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bitmap drained lowest-bit-first, with abort and empty-load rules.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_pend <= 32'd0;
            m_cnt  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (CLR) begin
                m_pend <= 32'd0;
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (LOAD) begin
                    m_pend <= REQ;
                    m_cnt  <= 0;
                    m_busy <= (REQ != 32'd0);
                    m_done <= (REQ == 32'd0);
                end
            end else if (ACK) begin
                m_pend <= m_pend & ~(32'd1 << lowest(m_pend));
                m_cnt  <= m_cnt + 1;
                if ((m_pend & ~(32'd1 << lowest(m_pend))) == 32'd0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Compare every DUT output with the model on each falling edge.
    always @(negedge CLK) begin
        check("cmp_valid", {31'd0, VALID}, {31'd0, m_busy});
        check("cmp_busy",  {31'd0, BUSY},  {31'd0, m_busy});
        check("cmp_idx",   {27'd0, IDX},   m_busy ? lowest(m_pend) : 32'd0);
        check("cmp_done",  {31'd0, DONE},  {31'd0, m_done});
        check("cmp_pend",  PEND,           m_pend);
        check("cmp_cnt",   {26'd0, CNT},   m_cnt);
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int done_seen;
        // Reset state
        cyc; cyc;
        check("rst_valid", {31'd0, VALID}, 32'd0);
        check("rst_idx",   {27'd0, IDX},   32'd0);
        check("rst_done",  {31'd0, DONE},  32'd0);
        check("rst_pend",  PEND,           32'd0);
        RESET = 1'b0;
        cyc;

        // Basic drain: 0, 2, 31
        LOAD = 1'b1; REQ = 32'h8000_0005; ACK = 1'b1;
        cyc; LOAD = 1'b0;
        check("drain_v0", {31'd0, VALID}, 32'd1);
        check("drain_i0", {27'd0, IDX}, 32'd0);
        cyc; check("drain_i2", {27'd0, IDX}, 32'd2);
        cyc; check("drain_i31", {27'd0, IDX}, 32'd31);
        cyc; ACK = 1'b0;
        check("drain_done", {31'd0, DONE}, 32'd1);
        check("drain_cnt", {26'd0, CNT}, 32'd3);
        check("drain_vlo", {31'd0, VALID}, 32'd0);
        cyc; check("drain_done_lo", {31'd0, DONE}, 32'd0);

        // Backpressure
        LOAD = 1'b1; REQ = 32'h0000_0300;
        cyc; LOAD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("bp_hold_idx", {27'd0, IDX}, 32'd8);
            check("bp_hold_v", {31'd0, VALID}, 32'd1);
            cyc;
        end
        ACK = 1'b1;
        cyc; check("bp_idx9", {27'd0, IDX}, 32'd9);
        cyc; ACK = 1'b0;
        check("bp_done", {31'd0, DONE}, 32'd1);
        cyc;

        // Empty load
        LOAD = 1'b1; REQ = 32'd0;
        cyc; LOAD = 1'b0;
        check("empty_done", {31'd0, DONE}, 32'd1);
        check("empty_v", {31'd0, VALID}, 32'd0);
        check("empty_cnt", {26'd0, CNT}, 32'd0);
        cyc; check("empty_done_lo", {31'd0, DONE}, 32'd0);

        // Abort priority with PEND=6, CNT=1; LOAD in EMIT ignored
        LOAD = 1'b1; REQ = 32'h0000_0007;
        cyc; LOAD = 1'b0; ACK = 1'b1;
        cyc; ACK = 1'b0;
        check("abort_pend6", PEND, 32'h6);
        LOAD = 1'b1; REQ = 32'h0000_00F0;
        cyc; LOAD = 1'b0;
        check("load_ignored", PEND, 32'h6);
        check("abort_idx1", {27'd0, IDX}, 32'd1);
        CLR = 1'b1; ACK = 1'b1;
        cyc; CLR = 1'b0; ACK = 1'b0;
        check("abort_v", {31'd0, VALID}, 32'd0);
        check("abort_pend", PEND, 32'd0);
        check("abort_nodone", {31'd0, DONE}, 32'd0);
        check("abort_cnt", {26'd0, CNT}, 32'd1);
        cyc;

        // Full map
        LOAD = 1'b1; REQ = 32'hFFFF_FFFF; ACK = 1'b1;
        cyc; LOAD = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 32; k++) begin
            check("full_idx", {27'd0, IDX}, k);
            if (DONE) done_seen++;
            cyc;
        end
        ACK = 1'b0;
        check("full_done", {31'd0, DONE}, 32'd1);
        check("full_cnt", {26'd0, CNT}, 32'd32);
        cyc;
        check("full_done_once", done_seen + (DONE ? 1 : 0), 32'd0);

        // Reset mid-EMIT
        LOAD = 1'b1; REQ = 32'h0000_00F0;
        cyc; LOAD = 1'b0; ACK = 1'b1;
        cyc; ACK = 1'b0;
        check("mid_idx5", {27'd0, IDX}, 32'd5);
        check("mid_cnt1", {26'd0, CNT}, 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_v", {31'd0, VALID}, 32'd0);
        check("mid_rst_pend", PEND, 32'd0);
        check("mid_rst_cnt", {26'd0, CNT}, 32'd0);
        check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        cyc; RESET = 1'b0;
        cyc;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            LOAD = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: REQ = 32'd0;
                1: REQ = 32'd1 << $urandom_range(0, 31);
                2: REQ = $urandom;
                default: REQ = $urandom & $urandom & $urandom;
            endcase
            ACK = ($urandom_range(0, 2) != 0);
            CLR = ($urandom_range(0, 40) == 0);
            cyc;
        end
        LOAD = 1'b0; ACK = 1'b0; CLR = 1'b0;
        cyc; cyc;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pending_encoder_32x5.md
Name: pending_encoder_32x5

Overview:
- Sequential 32-to-5 encoder; the inverse of the 5x32 line decoder.
- Captures a 32-bit one-hot/multi-hot request bitmap (e.g. register-write masks, interrupt lines) and serially emits the 5-bit index of each set bit, lowest index first.
- Each index is emitted under a VALID/ACK handshake; DONE pulses when the bitmap is exhausted.
- Sits between bitmap-producing control logic and index-consuming blocks such as register-file address ports.

Parameters:
- WIDTH, 32, request bitmap width.
- IDXW, 5, index width; must equal log2(WIDTH).
- CNTW, 6, served-count width; must equal IDXW+1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- LOAD  input  1  capture REQ when idle.
- REQ  input  WIDTH  request bitmap.
- CLR  input  1  synchronous abort; drops all pending bits.
- ACK  input  1  consumer accepts current IDX.
- VALID  output  1  IDX holds a pending index.
- IDX  output  IDXW  lowest set index of the pending register.
- BUSY  output  1  high in the EMIT state.
- DONE  output  1  one-cycle pulse when the last index is accepted, or when an empty bitmap is loaded.
- PEND  output  WIDTH  current pending register.
- CNT  output  CNTW  indices accepted since the last LOAD.

Behaviour:
- Reset (RESET=1, asynchronous, effective immediately including mid-operation): state=IDLE, PEND=0, CNT=0, VALID=0, IDX=0, BUSY=0, DONE=0.
- States: IDLE, EMIT. Encoding is 1 bit: IDLE=0, EMIT=1.
- IDLE:
  - LOAD=1, REQ!=0 → at the edge PEND<=REQ, CNT<=0, go to EMIT. VALID is high in the following cycle (1-cycle latency).
  - LOAD=1, REQ=0 → PEND<=0, CNT<=0, DONE=1 next cycle, stay in IDLE.
  - LOAD=0 → hold all state.
- EMIT:
  - VALID=1, BUSY=1.
  - IDX = index of the lowest set bit of PEND, computed combinationally from the registered PEND.
  - IDX is stable while ACK=0, and ACK may be held low indefinitely.
  - ACK=1 → at the edge clear bit IDX of PEND and CNT<=CNT+1.
  - If the cleared PEND becomes 0 → DONE=1 next cycle, go to IDLE. Otherwise stay in EMIT with the next index visible next cycle.
  - Throughput: one index per cycle with ACK held high. N set bits need N ACK cycles.
- LOAD in EMIT is ignored; no merge into PEND.
- CLR=1 (either state) → PEND<=0, go to IDLE, no DONE pulse, CNT holds its value.
  - CLR has priority over ACK and LOAD in the same cycle.
- ACK while VALID=0 is ignored.
- DONE is registered and high for exactly one cycle, coincident with the first IDLE cycle.
- VALID=0 implies IDX=0.
- Lowest-bit isolation: iso = PEND & (~PEND + 1), using two's-complement arithmetic in WIDTH bits. The encoder then maps one-hot iso to IDX.
- Bit 31 alone → IDX=31. Full bitmap 32'hFFFFFFFF → 32 emissions, CNT ends at 32 (needs all 6 bits, no wrap).

Decomposition:
- Shared definitions include: state encodings (`PE_IDLE`, `PE_EMIT`), WIDTH/IDXW defaults.
- One sub-module: priority_enc_32x5.
  - Combinational, inputs PEND[31:0], outputs IDX[4:0] and a NZ flag.
  - Built from lowest-bit isolate plus one-hot-to-binary OR trees.
- The top level holds the FSM, PEND, CNT and DONE registers.

Test Plan:
- Reset mid-EMIT: load 32'h0000_00F0, ACK once, assert RESET → same cycle VALID=0, PEND=0, CNT=0, BUSY=0.
- Basic drain: LOAD REQ=32'h8000_0005, ACK held high → IDX sequence 0, 2, 31 on consecutive cycles. DONE pulses the cycle after IDX=31 is accepted; CNT=3.
- Backpressure: LOAD 32'h0000_0300, ACK low for 4 cycles → IDX stays 8 with VALID=1. Then ACK → IDX=9, then DONE.
- Empty load: LOAD REQ=0 in IDLE → DONE one cycle, VALID never asserted, CNT=0.
- Abort priority: in EMIT with PEND=32'h0000_0006, CLR=1 and ACK=1 together → IDLE, PEND=0, no DONE, CNT unchanged. LOAD during EMIT is ignored (PEND unchanged).
- Full map: LOAD 32'hFFFF_FFFF, ACK held high → IDX 0..31 over 32 cycles, CNT=32, single DONE pulse.
